// File: rtl/led_blink_if.sv
// Purpose: pin bundle between the board button/LED and the blink controller.
// Signals:
//   btn_in     - raw asynchronous push-button, active-high
//   led_out    - registered LED drive
//   mode_o     - selected blink mode (0 off, 1 slow, 2 fast, 3 on)
//   long_pulse - one-cycle pulse when a hold becomes long
//   btn_db     - debounced button level
// Modports: slave = controller side, master = board/stimulus side.
interface led_blink_if;
  logic       btn_in;
  logic       led_out;
  logic [1:0] mode_o;
  logic       long_pulse;
  logic       btn_db;

  modport slave (
    input  btn_in,
    output led_out,
    output mode_o,
    output long_pulse,
    output btn_db
  );

  modport master (
    output btn_in,
    input  led_out,
    input  mode_o,
    input  long_pulse,
    input  btn_db
  );
endinterface

// File: rtl/led_blink_ctrl.sv
// Purpose: button-driven LED blink controller. Synchronises and debounces a raw
// push-button, classifies presses as short or long, cycles the blink mode on
// each short press and forces fast blink while a press is held long.
// Ports:
//   clk   - single clock, all logic on posedge
//   reset - asynchronous active-high reset
//   bus   - led_blink_if.slave: btn_in in; led_out, mode_o, long_pulse, btn_db out
module led_blink_ctrl #(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned SLOW_BIT        = 30,
  parameter int unsigned FAST_BIT        = 29,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned LONG_CYCLES     = 125000000
) (
  input logic         clk,
  input logic         reset,
  led_blink_if.slave  bus
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_DB  = 3'd1,
    HELD      = 3'd2,
    LONG_HELD = 3'd3,
    REL_DB    = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    counter;
  logic [DB_W-1:0]     db_cnt, db_cnt_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic                short_q, short_nxt;
  logic [1:0]          mode_q, mode_nxt;
  logic                long_q, long_nxt;
  logic                btn_db_q, btn_db_nxt;
  logic                led_q, led_nxt;
  logic                sync1, btn_s;
  logic                override;

  // Two-flop synchroniser for the raw button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= bus.btn_in;
      btn_s <= sync1;
    end
  end

  // Free-running blink counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) counter <= '0;
    else       counter <= counter + CNT_W'(1);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      db_cnt   <= '0;
      hold_cnt <= '0;
      short_q  <= 1'b0;
      mode_q   <= 2'd1;
      long_q   <= 1'b0;
      btn_db_q <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      db_cnt   <= db_cnt_nxt;
      hold_cnt <= hold_cnt_nxt;
      short_q  <= short_nxt;
      mode_q   <= mode_nxt;
      long_q   <= long_nxt;
      btn_db_q <= btn_db_nxt;
      led_q    <= led_nxt;
    end
  end

  // Press classification FSM
  always_comb begin
    state_nxt    = state;
    db_cnt_nxt   = db_cnt;
    hold_cnt_nxt = hold_cnt;
    short_nxt    = short_q;
    mode_nxt     = mode_q;
    long_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt  = PRESS_DB;
          db_cnt_nxt = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_nxt    = HELD;
          hold_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt  = REL_DB;
          short_nxt  = 1'b1;
          db_cnt_nxt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      LONG_HELD: begin
        if (!btn_s) begin
          state_nxt  = REL_DB;
          short_nxt  = 1'b0;
          db_cnt_nxt = '0;
        end
      end
      REL_DB: begin
        // A bounce back to pressed resumes the same hold; hold_cnt is kept
        if (btn_s) begin
          state_nxt = short_q ? HELD : LONG_HELD;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = IDLE;
          if (short_q) mode_nxt = mode_q + 2'd1;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Registered from next state so btn_db lines up exactly with the state
    btn_db_nxt = (state_nxt == HELD) || (state_nxt == LONG_HELD) || (state_nxt == REL_DB);
  end

  // LED source select; long holds force fast blink until the release settles
  always_comb begin
    override = (state == LONG_HELD) || ((state == REL_DB) && !short_q);
    led_nxt  = 1'b0;
    if (override) begin
      led_nxt = counter[FAST_BIT];
    end else begin
      case (mode_q)
        2'd0:    led_nxt = 1'b0;
        2'd1:    led_nxt = counter[SLOW_BIT];
        2'd2:    led_nxt = counter[FAST_BIT];
        default: led_nxt = 1'b1;
      endcase
    end
  end

  assign bus.led_out    = led_q;
  assign bus.mode_o     = mode_q;
  assign bus.long_pulse = long_q;
  assign bus.btn_db     = btn_db_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Purpose: directed self-checking bench for led_blink_ctrl with small timing
// parameters (CNT_W=8, SLOW_BIT=5, FAST_BIT=3, DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
module tb_led_blink_ctrl;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned SLOW_BIT = 5;
  localparam int unsigned FAST_BIT = 3;
  localparam int unsigned DB_CYC   = 4;
  localparam int unsigned LONG_CYC = 20;

  logic clk;
  logic reset;
  led_blink_if bus();

  led_blink_ctrl #(
    .CNT_W(CNT_W), .SLOW_BIT(SLOW_BIT), .FAST_BIT(FAST_BIT),
    .DEBOUNCE_CYCLES(DB_CYC), .LONG_CYCLES(LONG_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference blink counter: value after each edge equals edges since reset
  logic [7:0] tb_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cnt <= 8'd0;
    else       tb_cnt <= tb_cnt + 8'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // LED value expected right after an edge: driven by the counter before it
  function automatic logic exp_led(input logic [1:0] mode, input logic ovr);
    logic [7:0] c;
    c = tb_cnt - 8'd1;
    if (ovr) return c[FAST_BIT];
    case (mode)
      2'd0:    return 1'b0;
      2'd1:    return c[SLOW_BIT];
      2'd2:    return c[FAST_BIT];
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.btn_in = 1'b0;
    #3;
    checks++; if (bus.led_out !== 1'b0) begin failures++; $display("FAIL reset_led got=%0b exp=0", bus.led_out); end
    checks++; if (bus.mode_o !== 2'd1) begin failures++; $display("FAIL reset_mode got=%0d exp=1", bus.mode_o); end
    checks++; if (bus.long_pulse !== 1'b0) begin failures++; $display("FAIL reset_long got=%0b exp=0", bus.long_pulse); end
    checks++; if (bus.btn_db !== 1'b0) begin failures++; $display("FAIL reset_btn_db got=%0b exp=0", bus.btn_db); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 128; n++) begin
      tick();
      checks++;
      if (bus.led_out !== exp_led(2'd1, 1'b0)) begin
        failures++; $display("FAIL idle_slow_led cyc=%0d got=%0b exp=%0b", n, bus.led_out, exp_led(2'd1, 1'b0));
      end
      checks++;
      if (bus.long_pulse !== 1'b0) begin failures++; $display("FAIL idle_long cyc=%0d got=%0b exp=0", n, bus.long_pulse); end
    end
    checks++; if (bus.mode_o !== 2'd1) begin failures++; $display("FAIL idle_mode got=%0d exp=1", bus.mode_o); end
  endtask

  task automatic test_glitch();
    bus.btn_in = 1'b1;
    repeat (3) tick();
    bus.btn_in = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (bus.btn_db !== 1'b0) begin failures++; $display("FAIL glitch_btn_db cyc=%0d got=%0b exp=0", n, bus.btn_db); end
    end
    checks++; if (bus.mode_o !== 2'd1) begin failures++; $display("FAIL glitch_mode got=%0d exp=1", bus.mode_o); end
  endtask

  task automatic test_short_press();
    logic [1:0] seq [4];
    logic [1:0] prev;
    seq = '{2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      prev = 2'(seq[i] - 2'd1);
      bus.btn_in = 1'b1;
      repeat (10) tick();
      checks++; if (bus.btn_db !== 1'b1) begin failures++; $display("FAIL short_btn_db press=%0d got=%0b exp=1", i, bus.btn_db); end
      bus.btn_in = 1'b0;
      repeat (6) tick();
      checks++; if (bus.mode_o !== prev) begin failures++; $display("FAIL short_mode_early press=%0d got=%0d exp=%0d", i, bus.mode_o, prev); end
      tick();
      checks++; if (bus.mode_o !== seq[i]) begin failures++; $display("FAIL short_mode press=%0d got=%0d exp=%0d", i, bus.mode_o, seq[i]); end
      repeat (2) tick();
      for (int n = 0; n < 16; n++) begin
        tick();
        checks++;
        if (bus.led_out !== exp_led(seq[i], 1'b0)) begin
          failures++; $display("FAIL short_led mode=%0d cyc=%0d got=%0b exp=%0b", seq[i], n, bus.led_out, exp_led(seq[i], 1'b0));
        end
      end
    end
  endtask

  task automatic test_long_press();
    logic exp_lp;
    bus.btn_in = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      tick();
      exp_lp = (j == 27);
      checks++;
      if (bus.long_pulse !== exp_lp) begin failures++; $display("FAIL long_pulse cyc=%0d got=%0b exp=%0b", j, bus.long_pulse, exp_lp); end
      if (j >= 28) begin
        checks++;
        if (bus.led_out !== exp_led(2'd1, 1'b1)) begin
          failures++; $display("FAIL long_led_fast cyc=%0d got=%0b exp=%0b", j, bus.led_out, exp_led(2'd1, 1'b1));
        end
      end
    end
    bus.btn_in = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (bus.led_out !== exp_led(2'd1, i <= 7)) begin
        failures++; $display("FAIL long_release_led cyc=%0d got=%0b exp=%0b", i, bus.led_out, exp_led(2'd1, i <= 7));
      end
      checks++;
      if (bus.long_pulse !== 1'b0) begin failures++; $display("FAIL long_release_pulse cyc=%0d got=%0b exp=0", i, bus.long_pulse); end
    end
    checks++; if (bus.mode_o !== 2'd1) begin failures++; $display("FAIL long_mode got=%0d exp=1", bus.mode_o); end
    checks++; if (bus.btn_db !== 1'b0) begin failures++; $display("FAIL long_btn_db got=%0b exp=0", bus.btn_db); end
  endtask

  task automatic test_release_bounce();
    bus.btn_in = 1'b1;
    repeat (10) tick();
    bus.btn_in = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++; if (bus.btn_db !== 1'b1) begin failures++; $display("FAIL bounce_btn_db_low cyc=%0d got=%0b exp=1", n, bus.btn_db); end
    end
    bus.btn_in = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++; if (bus.btn_db !== 1'b1) begin failures++; $display("FAIL bounce_btn_db_high cyc=%0d got=%0b exp=1", n, bus.btn_db); end
      checks++; if (bus.mode_o !== 2'd1) begin failures++; $display("FAIL bounce_mode cyc=%0d got=%0d exp=1", n, bus.mode_o); end
      checks++; if (bus.long_pulse !== 1'b0) begin failures++; $display("FAIL bounce_long cyc=%0d got=%0b exp=0", n, bus.long_pulse); end
    end
    bus.btn_in = 1'b0;
    repeat (6) tick();
    checks++; if (bus.mode_o !== 2'd1) begin failures++; $display("FAIL bounce_mode_early got=%0d exp=1", bus.mode_o); end
    tick();
    checks++; if (bus.mode_o !== 2'd2) begin failures++; $display("FAIL bounce_mode_final got=%0d exp=2", bus.mode_o); end
    repeat (4) tick();
    checks++; if (bus.mode_o !== 2'd2) begin failures++; $display("FAIL bounce_mode_stable got=%0d exp=2", bus.mode_o); end
  endtask

  task automatic test_async_reset();
    bus.btn_in = 1'b1;
    repeat (30) tick();
    checks++; if (bus.btn_db !== 1'b1) begin failures++; $display("FAIL areset_pre_btn_db got=%0b exp=1", bus.btn_db); end
    #2;
    reset = 1'b1;
    bus.btn_in = 1'b0;
    #1;
    checks++; if (bus.led_out !== 1'b0) begin failures++; $display("FAIL areset_led got=%0b exp=0", bus.led_out); end
    checks++; if (bus.long_pulse !== 1'b0) begin failures++; $display("FAIL areset_long got=%0b exp=0", bus.long_pulse); end
    checks++; if (bus.btn_db !== 1'b0) begin failures++; $display("FAIL areset_btn_db got=%0b exp=0", bus.btn_db); end
    checks++; if (bus.mode_o !== 2'd1) begin failures++; $display("FAIL areset_mode got=%0d exp=1", bus.mode_o); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      checks++;
      if (bus.led_out !== exp_led(2'd1, 1'b0)) begin
        failures++; $display("FAIL areset_led_restart cyc=%0d got=%0b exp=%0b", n, bus.led_out, exp_led(2'd1, 1'b0));
      end
    end
    checks++; if (bus.mode_o !== 2'd1) begin failures++; $display("FAIL areset_mode_after got=%0d exp=1", bus.mode_o); end
    checks++; if (bus.btn_db !== 1'b0) begin failures++; $display("FAIL areset_btn_db_after got=%0b exp=0", bus.btn_db); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_short_press();
    test_long_press();
    test_release_bounce();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
